ann_layer_sequencer: RTL and testbench



---
 rtl/ann_pkg.sv | 26 ++
 rtl/ann_addr_gen.sv | 36 +++
 rtl/ann_layer_sequencer.sv | 143 ++++++++++++++
 tb/tb_ann_layer_sequencer.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/ann_pkg.sv
// Shared types and layer table for the ANN layer sequencer.
// ANN_BIAS_EN selects the bias layout: one extra coefficient word per neuron row.
package ann_pkg;

  localparam int unsigned MAX_LAYERS = 4;

  typedef enum logic [2:0] {
    StIdle,
    StClear,
    StMac,
    StDrain,
    StWrite,
    StDone
  } seq_state_t;

  localparam int unsigned LAYER_N_IN  [MAX_LAYERS] = '{64, 32, 16, 16};
  localparam int unsigned LAYER_N_OUT [MAX_LAYERS] = '{32, 16, 16, 10};

`ifdef ANN_BIAS_EN
  // Rows are n_in + 1 words long; the bias word sits at the end of each row.
  localparam int unsigned LAYER_BASE  [MAX_LAYERS] = '{0, 2080, 2608, 2880};
`else
  localparam int unsigned LAYER_BASE  [MAX_LAYERS] = '{0, 2048, 2560, 2816};
`endif

endpackage

// File: rtl/ann_addr_gen.sv
// Input/neuron/coefficient-pointer counters for the layer sequencer.
// load restarts a layer, advance steps one MAC beat, next_neuron moves to the next row.
module ann_addr_gen #(
  parameter int unsigned ADDR_W = 12
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic              load,
  input  logic [ADDR_W-1:0] base,
  input  logic              advance,
  input  logic              next_neuron,
  output logic [6:0]        inp,
  output logic [6:0]        neuron,
  output logic [ADDR_W-1:0] ptr
);

  // Counter registers; ptr is never rewound between neurons since rows are contiguous.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      inp    <= '0;
      neuron <= '0;
      ptr    <= '0;
    end else if (load) begin
      inp    <= '0;
      neuron <= '0;
      ptr    <= base;
    end else if (next_neuron) begin
      inp    <= '0;
      neuron <= neuron + 7'd1;
    end else if (advance) begin
      inp    <= inp + 7'd1;
      ptr    <= ptr + 1'b1;
    end
  end

endmodule

// File: rtl/ann_layer_sequencer.sv
// Sequences one fully-connected layer: clear, MAC over inputs, drain, write, per neuron.
// ANN_BIAS_EN adds a bias beat per neuron and the bias_sel output.
module ann_layer_sequencer
  import ann_pkg::*;
#(
  parameter int unsigned ADDR_W     = 12,
  parameter int unsigned MAC_LAT    = 2,
  parameter int unsigned NUM_LAYERS = 4
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic              start,
  input  logic [1:0]        layer_sel,
  input  logic              coef_ready,
  output logic [6:0]        in_addr,
  output logic [ADDR_W-1:0] coef_addr,
  output logic              mac_en,
  output logic              clear_acc,
  output logic              act_wr,
  output logic [6:0]        out_addr,
  output logic              busy,
  output logic              layer_done
`ifdef ANN_BIAS_EN
  ,
  output logic              bias_sel
`endif
);

  localparam int unsigned DW = (MAC_LAT > 1) ? $clog2(MAC_LAT) : 1;

  seq_state_t        state_q, state_d;
  logic [DW-1:0]     drain_q, drain_d;
  logic [6:0]        n_in_q, n_out_q;
  logic              load, advance, next_neuron;
  logic              start_ok, last_beat;
  logic [6:0]        inp, neuron;
  logic [ADDR_W-1:0] ptr;

  assign start_ok = start && (32'(layer_sel) < NUM_LAYERS);

`ifdef ANN_BIAS_EN
  logic bias_beat;
  assign bias_beat = (inp == n_in_q);
  assign last_beat = bias_beat;
  assign bias_sel  = (state_q == StMac) && bias_beat;
  assign in_addr   = bias_sel ? 7'd0 : inp;
`else
  assign last_beat = (inp == n_in_q - 7'd1);
  assign in_addr   = inp;
`endif

  assign coef_addr = ptr;
  assign out_addr  = neuron;

  ann_addr_gen #(
    .ADDR_W(ADDR_W)
  ) u_addr_gen (
    .clk        (clk),
    .n_rst      (n_rst),
    .load       (load),
    .base       (ADDR_W'(LAYER_BASE[layer_sel])),
    .advance    (advance),
    .next_neuron(next_neuron),
    .inp        (inp),
    .neuron     (neuron),
    .ptr        (ptr)
  );

  // State, drain counter and per-layer sizes latched at start.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q <= StIdle;
      drain_q <= '0;
      n_in_q  <= '0;
      n_out_q <= '0;
    end else begin
      state_q <= state_d;
      drain_q <= drain_d;
      if (load) begin
        n_in_q  <= 7'(LAYER_N_IN[layer_sel]);
        n_out_q <= 7'(LAYER_N_OUT[layer_sel]);
      end
    end
  end

  // Next-state and control decode; mac_en follows coef_ready only inside MAC.
  always_comb begin
    state_d     = state_q;
    drain_d     = drain_q;
    load        = 1'b0;
    advance     = 1'b0;
    next_neuron = 1'b0;
    mac_en      = 1'b0;
    clear_acc   = 1'b0;
    act_wr      = 1'b0;
    layer_done  = 1'b0;
    busy        = (state_q != StIdle);
    unique case (state_q)
      StIdle: begin
        if (start_ok) begin
          load    = 1'b1;
          state_d = StClear;
        end
      end
      StClear: begin
        clear_acc = 1'b1;
        state_d   = StMac;
      end
      StMac: begin
        if (coef_ready) begin
          mac_en  = 1'b1;
          advance = 1'b1;
          if (last_beat) begin
            state_d = StDrain;
            drain_d = '0;
          end
        end
      end
      StDrain: begin
        if (drain_q == DW'(MAC_LAT - 1)) begin
          state_d = StWrite;
        end else begin
          drain_d = drain_q + 1'b1;
        end
      end
      StWrite: begin
        act_wr = 1'b1;
        if (neuron == n_out_q - 7'd1) begin
          state_d = StDone;
        end else begin
          next_neuron = 1'b1;
          state_d     = StClear;
        end
      end
      StDone: begin
        layer_done = 1'b1;
        state_d    = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

endmodule

// File: tb/tb_ann_layer_sequencer.sv
// Randomized bench for ann_layer_sequencer: a schedule model built from layer sizes,
// stall draws and the per-neuron clear/MAC/drain/write rule predicts every cycle.
module tb_ann_layer_sequencer;

  localparam int ADDR_W  = 12;
  localparam int MAC_LAT = 2;
`ifdef ANN_BIAS_EN
  localparam int B = 1;
`else
  localparam int B = 0;
`endif

  logic              clk = 1'b0;
  logic              n_rst, start, coef_ready, start3;
  logic [1:0]        layer_sel, layer_sel3;
  logic [6:0]        in_addr, out_addr, in_addr3, out_addr3;
  logic [ADDR_W-1:0] coef_addr, coef_addr3;
  logic              mac_en, clear_acc, act_wr, busy, layer_done;
  logic              mac_en3, clear_acc3, act_wr3, busy3, layer_done3;
`ifdef ANN_BIAS_EN
  logic              bias_sel, bias_sel3;
`endif

  int errors = 0;
  int checks = 0;

  int n_in_t  [4] = '{64, 32, 16, 16};
  int n_out_t [4] = '{32, 16, 16, 10};

  always #5 clk = ~clk;

  ann_layer_sequencer #(.ADDR_W(ADDR_W), .MAC_LAT(MAC_LAT), .NUM_LAYERS(4)) dut (
    .clk(clk), .n_rst(n_rst), .start(start), .layer_sel(layer_sel), .coef_ready(coef_ready),
    .in_addr(in_addr), .coef_addr(coef_addr), .mac_en(mac_en), .clear_acc(clear_acc),
    .act_wr(act_wr), .out_addr(out_addr), .busy(busy), .layer_done(layer_done)
`ifdef ANN_BIAS_EN
    , .bias_sel(bias_sel)
`endif
  );

  ann_layer_sequencer #(.ADDR_W(ADDR_W), .MAC_LAT(MAC_LAT), .NUM_LAYERS(3)) dut3 (
    .clk(clk), .n_rst(n_rst), .start(start3), .layer_sel(layer_sel3), .coef_ready(coef_ready),
    .in_addr(in_addr3), .coef_addr(coef_addr3), .mac_en(mac_en3), .clear_acc(clear_acc3),
    .act_wr(act_wr3), .out_addr(out_addr3), .busy(busy3), .layer_done(layer_done3)
`ifdef ANN_BIAS_EN
    , .bias_sel(bias_sel3)
`endif
  );

  task automatic check_eq(input string tag, input int obs, input int exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h), want %0d (0x%0h) at %0t", tag, obs, obs, exp, exp,
               $time);
    end
  endtask

  // Packed rows: each layer's block follows the previous one.
  function automatic int base_of(input int l);
    int b = 0;
    for (int j = 0; j < l; j++) b += (n_in_t[j] + B) * n_out_t[j];
    return b;
  endfunction

  typedef struct {
    bit       rdy;
    bit [4:0] ctl;      // {mac_en, clear_acc, act_wr, layer_done, busy}
    bit       chk_in;
    int       in_a;
    int       c_a;
    bit       bias;
    bit       chk_out;
    int       o_a;
  } exp_t;

  // mode 0: no stalls, 1: random stalls, 2: five stall cycles before neuron 0 input 7.
  task automatic run_layer(input int l, input int mode, input bit poke);
    exp_t q[$];
    exp_t e;
    int   ptr, s, stalls_total, beats, done_obs, exp_lat;
    ptr          = base_of(l);
    beats        = n_in_t[l] + B;
    stalls_total = 0;
    done_obs     = -1;
    for (int k = 0; k < n_out_t[l]; k++) begin
      e = '{default: 0};
      e.rdy = 1'($urandom_range(0, 1));
      e.ctl = 5'b01001;
      q.push_back(e);
      for (int i = 0; i < beats; i++) begin
        if (mode == 1) s = ($urandom_range(0, 7) == 0) ? $urandom_range(1, 4) : 0;
        else if (mode == 2) s = (k == 0 && i == 7) ? 5 : 0;
        else s = 0;
        stalls_total += s;
        e = '{default: 0};
        e.chk_in = 1'b1;
        e.in_a   = (i >= n_in_t[l]) ? 0 : i;
        e.c_a    = ptr;
        e.bias   = (i >= n_in_t[l]);
        e.ctl    = 5'b00001;
        for (int j = 0; j < s; j++) q.push_back(e);
        e.rdy = 1'b1;
        e.ctl = 5'b10001;
        q.push_back(e);
        ptr++;
      end
      for (int d = 0; d < MAC_LAT; d++) begin
        e = '{default: 0};
        e.rdy = 1'($urandom_range(0, 1));
        e.ctl = 5'b00001;
        q.push_back(e);
      end
      e = '{default: 0};
      e.ctl = 5'b00101;
      e.chk_out = 1'b1;
      e.o_a = k;
      q.push_back(e);
    end
    e = '{default: 0};
    e.ctl = 5'b00011;
    q.push_back(e);
    exp_lat = n_out_t[l] * (1 + beats + MAC_LAT + 1) + stalls_total;

    @(negedge clk);
    start = 1'b1;
    layer_sel = 2'(l);
    coef_ready = 1'b0;
    @(negedge clk);
    start = 1'b0;
    for (int c = 0; c < q.size(); c++) begin
      coef_ready = q[c].rdy;
      if (poke && c == 5) begin
        start = 1'b1;
        layer_sel = 2'($urandom_range(0, 3));
      end else begin
        start = 1'b0;
      end
      #1;
      check_eq($sformatf("ctl L%0d c%0d", l, c),
               int'({mac_en, clear_acc, act_wr, layer_done, busy}), int'(q[c].ctl));
      if (q[c].chk_in) begin
        check_eq($sformatf("in_addr L%0d c%0d", l, c), int'(in_addr), q[c].in_a);
        check_eq($sformatf("coef_addr L%0d c%0d", l, c), int'(coef_addr), q[c].c_a);
      end
`ifdef ANN_BIAS_EN
      check_eq($sformatf("bias_sel L%0d c%0d", l, c), int'(bias_sel), int'(q[c].bias));
`endif
      if (q[c].chk_out) check_eq($sformatf("out_addr L%0d c%0d", l, c), int'(out_addr), q[c].o_a);
      if (layer_done && done_obs < 0) done_obs = c;
      @(negedge clk);
    end
    start = 1'b0;
    #1;
    check_eq($sformatf("idle busy L%0d", l), int'(busy), 0);
    check_eq($sformatf("latency L%0d", l), done_obs, exp_lat);
  endtask

  initial begin
    n_rst = 1'b0;
    start = 1'b0;
    start3 = 1'b0;
    layer_sel = 2'd0;
    layer_sel3 = 2'd0;
    coef_ready = 1'b0;
    #2;
    check_eq("reset outs", int'({in_addr, coef_addr, mac_en, clear_acc, act_wr, out_addr}), 0);
    check_eq("reset busy/done", int'({busy, layer_done}), 0);
    @(negedge clk);
    n_rst = 1'b1;

    // Out-of-range layer on a 3-layer instance must not start it.
    @(negedge clk);
    start3 = 1'b1;
    layer_sel3 = 2'd3;
    @(negedge clk);
    start3 = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      check_eq("sel3 ignored busy", int'(busy3), 0);
      check_eq("sel3 ignored addr", int'({coef_addr3, in_addr3, clear_acc3}), 0);
      @(negedge clk);
    end
    start3 = 1'b1;
    layer_sel3 = 2'd2;
    @(negedge clk);
    start3 = 1'b0;
    #1;
    check_eq("sel2 starts busy", int'(busy3), 1);
    check_eq("sel2 clear", int'(clear_acc3), 1);

    run_layer(3, 0, 1'b0);
    run_layer(1, 0, 1'b0);
    run_layer(2, 2, 1'b0);
    run_layer(2, 1, 1'b1);
    run_layer(3, 1, 1'b1);
    run_layer(0, 1, 1'b1);

    // Asynchronous reset in the middle of neuron 3's MAC phase of layer 0.
    @(negedge clk);
    start = 1'b1;
    layer_sel = 2'd0;
    coef_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3 * (n_in_t[0] + B + MAC_LAT + 2) + 11) @(negedge clk);
    #1;
    check_eq("pre-reset mac_en", int'(mac_en), 1);
    check_eq("pre-reset neuron", int'(out_addr), 3);
    n_rst = 1'b0;
    #1;
    check_eq("mid reset outs", int'({in_addr, coef_addr, mac_en, clear_acc, act_wr, out_addr}), 0);
    check_eq("mid reset busy/done", int'({busy, layer_done}), 0);
    @(negedge clk);
    n_rst = 1'b1;
    run_layer(0, 0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Hard time bound so the bench always ends.
  initial begin
    #2000000;
    $display("FAIL timeout: got no finish, want finish before 2000000");
    $fatal(1);
  end

endmodule
